alu_control_sequencer: RTL and testbench

ALU_CONTROL_SEQUENCER -- requirements
Module: alu_control_sequencer

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_op_decoder.sv | 57 +++++
 rtl/alu_control_sequencer.sv | 130 +++++++++++++
 tb/tb_alu_control_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control sequencer: operation codes,
// decode selector constants and the sequencer state enumeration.
package alu_pkg;

  // ALUOperation codes driven to the ALU
  localparam logic [3:0] OPC_AND      = 4'b0000;
  localparam logic [3:0] OPC_OR       = 4'b0001;
  localparam logic [3:0] OPC_NOR      = 4'b0010;
  localparam logic [3:0] OPC_ADD      = 4'b0011;
  localparam logic [3:0] OPC_SUB      = 4'b0100;
  localparam logic [3:0] OPC_INC      = 4'b0101;
  localparam logic [3:0] OPC_MUL_STEP = 4'b0110;
  localparam logic [3:0] OPC_MUL_ACC  = 4'b0111;
  localparam logic [3:0] OPC_ILLEGAL  = 4'b1001;

  // ALUOp classes from the main control unit
  localparam logic [2:0] OP_RTYPE  = 3'b111;
  localparam logic [2:0] OP_ADDI   = 3'b100;
  localparam logic [2:0] OP_ORI    = 3'b101;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_INC    = 3'b110;

  // Function-field values that matter for R-type and INC
  localparam logic [5:0] FN_AND      = 6'b100100;
  localparam logic [5:0] FN_OR       = 6'b100101;
  localparam logic [5:0] FN_NOR      = 6'b100111;
  localparam logic [5:0] FN_ADD      = 6'b100000;
  localparam logic [5:0] FN_INC      = 6'b110010;
  localparam logic [5:0] FN_MULTPLUS = 6'b110001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational selector decode: {op,func} -> ALU code, multi-cycle flag,
// illegal flag. Checks run in table order so the first match wins.
module alu_op_decoder
  import alu_pkg::*;
#(
  parameter int OP_W   = 3,
  parameter int FUNC_W = 6,
  parameter int OPER_W = 4
) (
  input  logic [OP_W-1:0]   op,
  input  logic [FUNC_W-1:0] func,
  output logic [OPER_W-1:0] code,
  output logic              multi,
  output logic              illegal
);

  logic rtype;

  assign rtype = (op == OP_W'(OP_RTYPE));

  // Priority decode of the selector; anything unmatched is illegal
  always_comb begin
    code    = OPER_W'(OPC_ILLEGAL);
    multi   = 1'b0;
    illegal = 1'b1;
    if (rtype && (func == FUNC_W'(FN_AND))) begin
      code    = OPER_W'(OPC_AND);
      illegal = 1'b0;
    end else if (rtype && (func == FUNC_W'(FN_OR))) begin
      code    = OPER_W'(OPC_OR);
      illegal = 1'b0;
    end else if (rtype && (func == FUNC_W'(FN_NOR))) begin
      code    = OPER_W'(OPC_NOR);
      illegal = 1'b0;
    end else if (rtype && (func == FUNC_W'(FN_ADD))) begin
      code    = OPER_W'(OPC_ADD);
      illegal = 1'b0;
    end else if (op == OP_W'(OP_ADDI)) begin
      code    = OPER_W'(OPC_ADD);
      illegal = 1'b0;
    end else if (op == OP_W'(OP_ORI)) begin
      code    = OPER_W'(OPC_OR);
      illegal = 1'b0;
    end else if (op == OP_W'(OP_BRANCH)) begin
      code    = OPER_W'(OPC_SUB);
      illegal = 1'b0;
    end else if ((op == OP_W'(OP_INC)) && (func == FUNC_W'(FN_INC))) begin
      code    = OPER_W'(OPC_INC);
      illegal = 1'b0;
    end else if (rtype && (func == FUNC_W'(FN_MULTPLUS))) begin
      code    = OPER_W'(OPC_MUL_STEP);
      multi   = 1'b1;
      illegal = 1'b0;
    end
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// ALU control sequencer: accepts decode requests, issues single-cycle ALU
// codes directly and walks MULTPLUS through DATA_W MUL_STEP cycles followed
// by one MUL_ACC cycle. All outputs except in_ready are registered.
module alu_control_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3,
  parameter int FUNC_W = 6,
  parameter int OPER_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_W-1:0]           ALUOp,
  input  logic [FUNC_W-1:0]         ALUFunction,
  input  logic                      flush,
  output logic [OPER_W-1:0]         ALUOperation,
  output logic                      oper_valid,
  output logic [$clog2(DATA_W)-1:0] step,
  output logic                      done,
  output logic                      illegal
);

  localparam int STEP_W = $clog2(DATA_W);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(DATA_W - 1);

  state_t              state;
  state_t              state_nxt;
  logic                armed;
  logic                accept;
  logic [OPER_W-1:0]   dec_code;
  logic                dec_multi;
  logic                dec_illegal;
  logic [OPER_W-1:0]   oper_nxt;
  logic                valid_nxt;
  logic                done_nxt;
  logic                illegal_nxt;
  logic [STEP_W-1:0]   step_nxt;

  alu_op_decoder #(
    .OP_W   (OP_W),
    .FUNC_W (FUNC_W),
    .OPER_W (OPER_W)
  ) u_decoder (
    .op      (ALUOp),
    .func    (ALUFunction),
    .code    (dec_code),
    .multi   (dec_multi),
    .illegal (dec_illegal)
  );

  assign in_ready = (state == ST_IDLE);
  // armed stays low for the first edge after reset release so a request
  // sitting on the bus when reset lifts is never taken on that edge.
  assign accept   = in_valid && in_ready && armed && !flush;

  // Next state and next registered outputs; flush overrides everything
  always_comb begin
    state_nxt   = state;
    oper_nxt    = OPER_W'(OPC_ILLEGAL);
    valid_nxt   = 1'b0;
    done_nxt    = 1'b0;
    illegal_nxt = 1'b0;
    step_nxt    = '0;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (dec_multi) begin
              state_nxt = ST_MUL;
              oper_nxt  = OPER_W'(OPC_MUL_STEP);
              valid_nxt = 1'b1;
            end else if (dec_illegal) begin
              done_nxt    = 1'b1;
              illegal_nxt = 1'b1;
            end else begin
              oper_nxt  = dec_code;
              valid_nxt = 1'b1;
              done_nxt  = 1'b1;
            end
          end
        end
        ST_MUL: begin
          valid_nxt = 1'b1;
          if (step == STEP_LAST) begin
            state_nxt = ST_ACC;
            oper_nxt  = OPER_W'(OPC_MUL_ACC);
            done_nxt  = 1'b1;
            step_nxt  = step;
          end else begin
            oper_nxt = OPER_W'(OPC_MUL_STEP);
            step_nxt = step + STEP_W'(1);
          end
        end
        ST_ACC: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      armed        <= 1'b0;
      ALUOperation <= OPER_W'(OPC_ILLEGAL);
      oper_valid   <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
      step         <= '0;
    end else begin
      state        <= state_nxt;
      armed        <= 1'b1;
      ALUOperation <= oper_nxt;
      oper_valid   <= valid_nxt;
      done         <= done_nxt;
      illegal      <= illegal_nxt;
      step         <= step_nxt;
    end
  end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Testbench for alu_control_sequencer: directed scenarios with literal
// expectations plus randomized traffic checked against a table-driven model.
module tb_alu_control_sequencer;

  localparam int DATA_W = 4;
  localparam int STEP_W = $clog2(DATA_W);

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        ALUOp;
  logic [5:0]        ALUFunction;
  logic              flush;
  logic [3:0]        ALUOperation;
  logic              oper_valid;
  logic [STEP_W-1:0] step;
  logic              done;
  logic              illegal;

  int checks = 0;
  int errors = 0;

  alu_control_sequencer #(
    .DATA_W (DATA_W),
    .OP_W   (3),
    .FUNC_W (6),
    .OPER_W (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ALUOp        (ALUOp),
    .ALUFunction  (ALUFunction),
    .flush        (flush),
    .ALUOperation (ALUOperation),
    .oper_valid   (oper_valid),
    .step         (step),
    .done         (done),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decode table in priority order: selector value, care mask, code.
  // Entry 8 (MULTPLUS) is the multi-cycle operation.
  localparam logic [8:0] TBL_VAL [9] = '{9'b111100100, 9'b111100101, 9'b111100111,
                                         9'b111100000, 9'b100000000, 9'b101000000,
                                         9'b001000000, 9'b110110010, 9'b111110001};
  localparam logic [8:0] TBL_MSK [9] = '{9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1C0,
                                         9'h1C0, 9'h1C0, 9'h1FF, 9'h1FF};
  localparam logic [3:0] TBL_CODE [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0011,
                                          4'b0001, 4'b0100, 4'b0101, 4'b0110};

  function automatic int ref_index(input logic [8:0] sel);
    int idx;
    idx = -1;
    for (int i = 0; i < 9; i++)
      if (idx < 0 && ((sel & TBL_MSK[i]) == TBL_VAL[i])) idx = i;
    return idx;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [2:0] op, input logic [5:0] fn, input logic fl);
    in_valid    = v;
    ALUOp       = op;
    ALUFunction = fn;
    flush       = fl;
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]        exp_op    = 4'b1001;
  logic              exp_ov    = 1'b0;
  logic              exp_done  = 1'b0;
  logic              exp_ill   = 1'b0;
  logic [STEP_W-1:0] exp_step  = '0;
  logic              exp_ready = 1'b1;
  int                mul_pos   = 0;   // next multiply output index; 0 = not multiplying
  logic              armed     = 1'b0;

  // Model: what the outputs must show after each edge
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_op <= 4'b1001; exp_ov <= 1'b0; exp_done <= 1'b0; exp_ill <= 1'b0;
      exp_step <= '0; exp_ready <= 1'b1; mul_pos <= 0; armed <= 1'b0;
    end else begin
      exp_op <= 4'b1001; exp_ov <= 1'b0; exp_done <= 1'b0; exp_ill <= 1'b0;
      exp_step <= '0; exp_ready <= 1'b1;
      armed <= 1'b1;
      if (flush) begin
        mul_pos <= 0;
      end else if (mul_pos > 0 && mul_pos < DATA_W) begin
        exp_op <= 4'b0110; exp_ov <= 1'b1; exp_step <= STEP_W'(mul_pos);
        exp_ready <= 1'b0; mul_pos <= mul_pos + 1;
      end else if (mul_pos == DATA_W) begin
        exp_op <= 4'b0111; exp_ov <= 1'b1; exp_done <= 1'b1;
        exp_step <= STEP_W'(DATA_W - 1); exp_ready <= 1'b0; mul_pos <= 0;
      end else if (in_valid && exp_ready && armed) begin
        if (ref_index({ALUOp, ALUFunction}) == 8) begin
          exp_op <= 4'b0110; exp_ov <= 1'b1; exp_step <= '0;
          exp_ready <= 1'b0; mul_pos <= 1;
        end else if (ref_index({ALUOp, ALUFunction}) < 0) begin
          exp_done <= 1'b1; exp_ill <= 1'b1;
        end else begin
          exp_op <= TBL_CODE[ref_index({ALUOp, ALUFunction})];
          exp_ov <= 1'b1; exp_done <= 1'b1;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    #1;
    check("m_op",    32'(ALUOperation), 32'(exp_op));
    check("m_valid", 32'(oper_valid),   32'(exp_ov));
    check("m_done",  32'(done),         32'(exp_done));
    check("m_ill",   32'(illegal),      32'(exp_ill));
    check("m_step",  32'(step),         32'(exp_step));
    check("m_ready", 32'(in_ready),     32'(exp_ready));
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [8:0] sel;
    int k;
    set_in(1'b0, 3'b000, 6'b000000, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_op",    32'(ALUOperation), 32'h9);
    check("rst_valid", 32'(oper_valid),   32'h0);
    check("rst_step",  32'(step),         32'h0);
    check("rst_ready", 32'(in_ready),     32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1 check("rel_ready", 32'(in_ready), 32'h1);
    @(negedge clk);

    // ADD, OR, INC back to back
    set_in(1'b1, 3'b111, 6'b100000, 1'b0);
    @(posedge clk); #2;
    check("add_op", 32'(ALUOperation), 32'h3); check("add_done", 32'(done), 32'h1);
    check("add_ready", 32'(in_ready), 32'h1);
    @(negedge clk); set_in(1'b1, 3'b111, 6'b100101, 1'b0);
    @(posedge clk); #2;
    check("or_op", 32'(ALUOperation), 32'h1); check("or_done", 32'(done), 32'h1);
    check("or_ready", 32'(in_ready), 32'h1);
    @(negedge clk); set_in(1'b1, 3'b110, 6'b110010, 1'b0);
    @(posedge clk); #2;
    check("inc_op", 32'(ALUOperation), 32'h5); check("inc_done", 32'(done), 32'h1);
    check("inc_ready", 32'(in_ready), 32'h1);

    // illegal selector
    @(negedge clk); set_in(1'b1, 3'b111, 6'b000111, 1'b0);
    @(posedge clk); #2;
    check("ill_op", 32'(ALUOperation), 32'h9); check("ill_valid", 32'(oper_valid), 32'h0);
    check("ill_flag", 32'(illegal), 32'h1);    check("ill_done", 32'(done), 32'h1);

    // full MULTPLUS
    @(negedge clk); set_in(1'b1, 3'b111, 6'b110001, 1'b0);
    for (int i = 0; i < DATA_W; i++) begin
      @(posedge clk); #2;
      set_in(1'b0, 3'b000, 6'b000000, 1'b0);
      check("mul_op", 32'(ALUOperation), 32'h6); check("mul_step", 32'(step), 32'(i));
      check("mul_ready", 32'(in_ready), 32'h0);  check("mul_done", 32'(done), 32'h0);
    end
    @(posedge clk); #2;
    check("acc_op", 32'(ALUOperation), 32'h7); check("acc_done", 32'(done), 32'h1);
    check("acc_step", 32'(step), 32'h3);       check("acc_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #2;
    check("post_ready", 32'(in_ready), 32'h1); check("post_valid", 32'(oper_valid), 32'h0);

    // flush at step 2
    @(negedge clk); set_in(1'b1, 3'b111, 6'b110001, 1'b0);
    @(posedge clk); #2; set_in(1'b0, 3'b000, 6'b000000, 1'b0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("fl_step2", 32'(step), 32'h2);
    set_in(1'b0, 3'b000, 6'b000000, 1'b1);
    @(posedge clk); #2;
    set_in(1'b0, 3'b000, 6'b000000, 1'b0);
    check("fl_valid", 32'(oper_valid), 32'h0); check("fl_step", 32'(step), 32'h0);
    check("fl_ready", 32'(in_ready), 32'h1);   check("fl_done", 32'(done), 32'h0);

    // request with simultaneous flush is dropped
    @(negedge clk); set_in(1'b1, 3'b111, 6'b100000, 1'b1);
    @(posedge clk); #2;
    set_in(1'b0, 3'b000, 6'b000000, 1'b0);
    check("fv_valid", 32'(oper_valid), 32'h0); check("fv_done", 32'(done), 32'h0);

    // reset mid-multiply, then ADDI after release
    @(negedge clk); set_in(1'b1, 3'b111, 6'b110001, 1'b0);
    @(posedge clk); #2; set_in(1'b0, 3'b000, 6'b000000, 1'b0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    check("mr_op", 32'(ALUOperation), 32'h9); check("mr_valid", 32'(oper_valid), 32'h0);
    check("mr_step", 32'(step), 32'h0);       check("mr_ready", 32'(in_ready), 32'h1);
    @(negedge clk); reset = 1'b1;
    #1 check("mr_rel_ready", 32'(in_ready), 32'h1);
    @(negedge clk); set_in(1'b1, 3'b100, 6'($urandom), 1'b0);
    @(posedge clk); #2;
    check("addi_op", 32'(ALUOperation), 32'h3); check("addi_valid", 32'(oper_valid), 32'h1);

    // randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 299) == 0) reset = 1'b0;
      k = $urandom_range(0, 11);
      if (k < 9) begin
        sel = TBL_VAL[k];
        if (TBL_MSK[k] == 9'h1C0) sel[5:0] = 6'($urandom);
      end else begin
        sel = 9'($urandom);
      end
      set_in(($urandom_range(0, 9) < 6), sel[8:6], sel[5:0], ($urandom_range(0, 29) == 0));
    end
    @(negedge clk);
    reset = 1'b1;
    set_in(1'b0, 3'b000, 6'b000000, 1'b0);
    repeat (8) @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
